even_ones_bit_feeder: RTL and testbench

//  Parallel-to-serial stage that sits directly upstream of the even-ones Mealy detector.

---
 rtl/even_ones_pkg.sv | 20 ++
 rtl/even_ones_bit_feeder_if.sv | 29 ++
 rtl/even_ones_bit_feeder.sv | 148 ++++++++++++++
 tb/tb_even_ones_bit_feeder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/even_ones_pkg.sv
// Shared definitions for the even-ones detector and its bit feeder.
package even_ones_pkg;

  // Feeder FSM encoding, shared with the detector side for debug visibility.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } feed_state_t;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the parity unchanged.
  localparam int POP_MAX = 256;

  // 1 when v holds an even number of ones.
  function automatic logic popcount_even(input logic [POP_MAX-1:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/even_ones_bit_feeder_if.sv
// Word handshake plus serial stream between a word source, the feeder and
// the even-ones detector.
interface even_ones_bit_feeder_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             w_out;
  logic             bit_vld;
  logic             sof;
  logic             eof;
  logic             exp_even;
  logic             busy;

  // Word source / stream observer side.
  modport master (
    output in_data, in_valid,
    input  in_ready, w_out, bit_vld, sof, eof, exp_even, busy
  );

  // Feeder side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, w_out, bit_vld, sof, eof, exp_even, busy
  );

endinterface

// File: rtl/even_ones_bit_feeder.sv
// Parallel-to-serial feeder for the even-ones Mealy detector. Words arrive on
// a valid/ready handshake and leave one bit per clock on w_out, framed by
// sof/eof, with the expected even-ones verdict on exp_even at eof. w_out is 0
// whenever no data bit is being sent so the detector's parity is not disturbed.
module even_ones_bit_feeder
  import even_ones_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  even_ones_bit_feeder_if.slave bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
  localparam logic [7:0]      GAP_LOAD = 8'(GAP);

  localparam logic [1:0] S_IDLE  = even_ones_pkg::IDLE;
  localparam logic [1:0] S_SHIFT = even_ones_pkg::SHIFT;
  localparam logic [1:0] S_GAP   = even_ones_pkg::GAP;

  // State registers and their next values.
  logic [1:0]       state,   state_n;
  logic [WIDTH-1:0] shreg,   shreg_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [7:0]       gap_cnt, gap_cnt_n;
  logic             par_q,   par_n;     // 1 = accepted word has odd ones

  // Output registers and their next values.
  logic in_ready_q, in_ready_n;
  logic w_out_q,    w_out_n;
  logic bit_vld_q,  bit_vld_n;
  logic sof_q,      sof_n;
  logic eof_q,      eof_n;
  logic exp_even_q, exp_even_n;
  logic busy_q,     busy_n;

  logic accept;

  // in_ready is a flop, so accept never depends combinationally on in_valid
  // feeding back into in_ready.
  assign accept = bus.in_valid & in_ready_q;

  // Next-state logic for the IDLE/SHIFT/GAP sequencer and the datapath.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    par_n     = par_q;

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n   = S_SHIFT;
          shreg_n   = bus.in_data;
          bit_cnt_n = '0;
          par_n     = ~popcount_even(POP_MAX'(bus.in_data));
        end
      end

      S_SHIFT: begin
        if (bit_cnt == LAST) begin
          if (GAP > 0) begin
            state_n   = S_GAP;
            gap_cnt_n = GAP_LOAD;
          end else if (accept) begin
            // Back-to-back word: its first bit follows the eof bit directly.
            shreg_n   = bus.in_data;
            bit_cnt_n = '0;
            par_n     = ~popcount_even(POP_MAX'(bus.in_data));
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
          if (MSB_FIRST) shreg_n = {shreg[WIDTH-2:0], 1'b0};
          else           shreg_n = {1'b0, shreg[WIDTH-1:1]};
        end
      end

      S_GAP: begin
        if (gap_cnt <= 8'd1) state_n   = S_IDLE;
        else                 gap_cnt_n = gap_cnt - 8'd1;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear, registered, in
  // the same cycle the state they describe is current.
  always_comb begin
    bit_vld_n  = (state_n == S_SHIFT);
    w_out_n    = bit_vld_n & (MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0]);
    sof_n      = bit_vld_n & (bit_cnt_n == '0);
    eof_n      = bit_vld_n & (bit_cnt_n == LAST);
    exp_even_n = eof_n & ~par_n;
    busy_n     = (state_n != S_IDLE);
    in_ready_n = (state_n == S_IDLE) | ((GAP == 0) & eof_n);
  end

  // State and output registers; reset abandons any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      par_q      <= 1'b0;
      in_ready_q <= 1'b0;
      w_out_q    <= 1'b0;
      bit_vld_q  <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      exp_even_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      par_q      <= par_n;
      in_ready_q <= in_ready_n;
      w_out_q    <= w_out_n;
      bit_vld_q  <= bit_vld_n;
      sof_q      <= sof_n;
      eof_q      <= eof_n;
      exp_even_q <= exp_even_n;
      busy_q     <= busy_n;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.w_out    = w_out_q;
  assign bus.bit_vld  = bit_vld_q;
  assign bus.sof      = sof_q;
  assign bus.eof      = eof_q;
  assign bus.exp_even = exp_even_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_even_ones_bit_feeder.sv
// Directed bench for even_ones_bit_feeder: four instances cover GAP=0/MSB
// first, GAP=2, LSB first and WIDTH=2. One instance is selected at a time.
module tb_even_ones_bit_feeder;

  logic       clk;
  logic       rst;
  logic [1:0] sel;
  logic [7:0] drv_data;
  logic       drv_valid;

  int test_cnt = 0;
  int fail_cnt = 0;

  even_ones_bit_feeder_if #(.WIDTH(8)) if_a ();
  even_ones_bit_feeder_if #(.WIDTH(8)) if_b ();
  even_ones_bit_feeder_if #(.WIDTH(8)) if_c ();
  even_ones_bit_feeder_if #(.WIDTH(2)) if_d ();

  assign if_a.in_data  = drv_data;
  assign if_b.in_data  = drv_data;
  assign if_c.in_data  = drv_data;
  assign if_d.in_data  = drv_data[1:0];
  assign if_a.in_valid = drv_valid & (sel == 2'd0);
  assign if_b.in_valid = drv_valid & (sel == 2'd1);
  assign if_c.in_valid = drv_valid & (sel == 2'd2);
  assign if_d.in_valid = drv_valid & (sel == 2'd3);

  even_ones_bit_feeder #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  even_ones_bit_feeder #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));
  even_ones_bit_feeder #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave));
  even_ones_bit_feeder #(.WIDTH(2), .GAP(0), .MSB_FIRST(1'b1)) dut_d (
    .clk(clk), .rst(rst), .bus(if_d.slave));

  // Outputs of the selected instance.
  logic o_ready, o_w, o_vld, o_sof, o_eof, o_even, o_busy;

  always_comb begin
    o_ready = if_a.in_ready; o_w = if_a.w_out; o_vld = if_a.bit_vld;
    o_sof = if_a.sof; o_eof = if_a.eof; o_even = if_a.exp_even; o_busy = if_a.busy;
    case (sel)
      2'd1: begin
        o_ready = if_b.in_ready; o_w = if_b.w_out; o_vld = if_b.bit_vld;
        o_sof = if_b.sof; o_eof = if_b.eof; o_even = if_b.exp_even; o_busy = if_b.busy;
      end
      2'd2: begin
        o_ready = if_c.in_ready; o_w = if_c.w_out; o_vld = if_c.bit_vld;
        o_sof = if_c.sof; o_eof = if_c.eof; o_even = if_c.exp_even; o_busy = if_c.busy;
      end
      2'd3: begin
        o_ready = if_d.in_ready; o_w = if_d.w_out; o_vld = if_d.bit_vld;
        o_sof = if_d.sof; o_eof = if_d.eof; o_even = if_d.exp_even; o_busy = if_d.busy;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected summary before 100000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Step one clock and move 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_ready);
    check({tag, " w_out"},    o_w,     1'b0);
    check({tag, " bit_vld"},  o_vld,   1'b0);
    check({tag, " sof"},      o_sof,   1'b0);
    check({tag, " eof"},      o_eof,   1'b0);
    check({tag, " exp_even"}, o_even,  1'b0);
    check({tag, " busy"},     o_busy,  1'b0);
    check({tag, " in_ready"}, o_ready, exp_ready);
  endtask

  task automatic check_gap(input string tag);
    check({tag, " w_out"},    o_w,     1'b0);
    check({tag, " bit_vld"},  o_vld,   1'b0);
    check({tag, " eof"},      o_eof,   1'b0);
    check({tag, " busy"},     o_busy,  1'b1);
    check({tag, " in_ready"}, o_ready, 1'b0);
  endtask

  // Present a word and take the accept edge; hold keeps in_valid high.
  task automatic accept_word(input string tag, input logic [7:0] d, input logic hold);
    drv_data  = d;
    drv_valid = 1'b1;
    check({tag, " ready_before_accept"}, o_ready, 1'b1);
    tick();
    if (!hold) drv_valid = 1'b0;
  endtask

  // Check one serialised word. seq[7] is the first expected bit, seq[6] the
  // second, and so on. A running parity of the observed bits models the
  // downstream detector's verdict after the last bit.
  task automatic serial_word(input string tag, input int width, input logic [7:0] seq,
                             input logic exp_ev, input logic eof_ready);
    logic par;
    par = 1'b0;
    for (int i = 0; i < width; i++) begin
      check($sformatf("%s b%0d w_out", tag, i),    o_w,     seq[7-i]);
      check($sformatf("%s b%0d bit_vld", tag, i),  o_vld,   1'b1);
      check($sformatf("%s b%0d sof", tag, i),      o_sof,   i == 0);
      check($sformatf("%s b%0d eof", tag, i),      o_eof,   i == width - 1);
      check($sformatf("%s b%0d exp_even", tag, i), o_even,  (i == width - 1) ? exp_ev : 1'b0);
      check($sformatf("%s b%0d in_ready", tag, i), o_ready, (i == width - 1) ? eof_ready : 1'b0);
      check($sformatf("%s b%0d busy", tag, i),     o_busy,  1'b1);
      par = par ^ o_w;
      tick();
    end
    drv_valid = 1'b0;
    check({tag, " detector_z"}, ~par, exp_ev);
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 2'd0;
    drv_data  = 8'h00;
    drv_valid = 1'b0;

    // Reset held: everything low, including in_ready.
    tick();
    tick();
    check_idle("reset", 1'b0);
    rst = 1'b0;
    tick();
    check_idle("post_reset", 1'b1);

    // A5 MSB first: 1,0,1,0,0,1,0,1; four ones -> even.
    accept_word("a5", 8'hA5, 1'b0);
    serial_word("a5", 8, 8'b1010_0101, 1'b1, 1'b1);
    check_idle("a5_done", 1'b1);

    // 07: 0,0,0,0,0,1,1,1; three ones -> odd.
    accept_word("h07", 8'h07, 1'b0);
    serial_word("h07", 8, 8'b0000_0111, 1'b0, 1'b1);
    check_idle("h07_done", 1'b1);

    // FF then 01 with in_valid held: 16 contiguous bits, second sof follows eof.
    accept_word("b2b", 8'hFF, 1'b1);
    drv_data = 8'h01;
    serial_word("b2b_ff", 8, 8'b1111_1111, 1'b1, 1'b1);
    serial_word("b2b_01", 8, 8'b0000_0001, 1'b0, 1'b1);
    check_idle("b2b_done", 1'b1);

    // GAP=2: two idle cycles with in_ready low, in_valid held and ignored.
    sel = 2'd1;
    accept_word("gap_a5", 8'hA5, 1'b0);
    serial_word("gap_a5", 8, 8'b1010_0101, 1'b1, 1'b0);
    drv_data  = 8'h3C;
    drv_valid = 1'b1;
    check_gap("gap_c1");
    tick();
    check_gap("gap_c2");
    tick();
    check_idle("gap_c3", 1'b1);
    accept_word("gap_3c", 8'h3C, 1'b0);
    serial_word("gap_3c", 8, 8'b0011_1100, 1'b1, 1'b0);
    check_gap("gap2_c1");
    tick();
    tick();
    check_idle("gap2_c3", 1'b1);

    // LSB first, 01: first bit 1 then seven zeros; one one -> odd.
    sel = 2'd2;
    accept_word("lsb_01", 8'h01, 1'b0);
    serial_word("lsb_01", 8, 8'b1000_0000, 1'b0, 1'b1);
    check_idle("lsb_done", 1'b1);

    // WIDTH=2 back-to-back: 10 (odd) then 11 (even).
    sel = 2'd3;
    accept_word("w2", 8'h02, 1'b1);
    drv_data = 8'h03;
    serial_word("w2_10", 2, 8'b1000_0000, 1'b0, 1'b1);
    serial_word("w2_11", 2, 8'b1100_0000, 1'b1, 1'b1);
    check_idle("w2_done", 1'b1);

    // Reset during bit 3 of A5: outputs drop at once, no eof, clean restart.
    sel = 2'd0;
    accept_word("rst_a5", 8'hA5, 1'b0);
    tick();
    tick();
    tick();
    check("rst_a5 b3 w_out",   o_w,   1'b0);
    check("rst_a5 b3 bit_vld", o_vld, 1'b1);
    check("rst_a5 b3 sof",     o_sof, 1'b0);
    rst = 1'b1;
    #1;
    check_idle("rst_async", 1'b0);
    tick();
    check_idle("rst_held", 1'b0);
    rst = 1'b0;
    tick();
    check_idle("rst_release", 1'b1);
    accept_word("rst_07", 8'h07, 1'b0);
    serial_word("rst_07", 8, 8'b0000_0111, 1'b0, 1'b1);
    check_idle("rst_07_done", 1'b1);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
